// File: rtl/render_pkg.sv
// Shared definitions for the board renderer: FSM state encoding and the
// default board geometry used by the renderer, its interface and sub-module.
package render_pkg;

  localparam int unsigned DefaultBoardN  = 8;   // cells per board side
  localparam int unsigned DefaultCellPx  = 28;  // pixels per cell side
  localparam int unsigned DefaultOriginX = 8;   // screen x of board top-left
  localparam int unsigned DefaultOriginY = 8;   // screen y of board top-left

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StDraw,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/board_renderer_if.sv
// Board renderer bus: control handshake, select-box inputs, board memory and
// picture ROM ports, and the pixel write port towards the VGA adapter.
//   master : the renderer side
//   slave  : the environment (memories, VGA adapter, controller)
interface board_renderer_if
  import render_pkg::*;
#(
  parameter int unsigned BOARD_N  = DefaultBoardN,
  parameter int unsigned CELL_PX  = DefaultCellPx,
  parameter int unsigned PIECE_W  = 4,
  parameter int unsigned COLOUR_W = 3
);
  localparam int unsigned CW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam int unsigned PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  logic                    start;
  logic [CW-1:0]           box_x;
  logic [CW-1:0]           box_y;
  logic                    box_en;
  logic [COLOUR_W-1:0]     box_colour;
  logic [PIECE_W-1:0]      piece_read;
  logic [COLOUR_W-1:0]     pic_pixel;
  logic [CW-1:0]           view_x;
  logic [CW-1:0]           view_y;
  logic [PIECE_W+2*PW-1:0] pic_addr;
  logic [8:0]              x;
  logic [7:0]              y;
  logic [COLOUR_W-1:0]     colour;
  logic                    writeEn;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, box_x, box_y, box_en, box_colour, piece_read, pic_pixel,
    output view_x, view_y, pic_addr, x, y, colour, writeEn, busy, done
  );

  modport slave (
    output start, box_x, box_y, box_en, box_colour, piece_read, pic_pixel,
    input  view_x, view_y, pic_addr, x, y, colour, writeEn, busy, done
  );

endinterface

// File: rtl/cell_pixel_counter.sv
// Raster pixel counter for one cell: px runs fastest, py steps when px wraps.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : return to (0,0); has priority over en_i
//   en_i          : advance one pixel
//   px_o, py_o    : current pixel within the cell
//   last_o        : current pixel is the last one of the cell
module cell_pixel_counter
  import render_pkg::*;
#(
  parameter int unsigned CELL_PX = DefaultCellPx,
  parameter int unsigned PW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          en_i,
  output logic [PW-1:0] px_o,
  output logic [PW-1:0] py_o,
  output logic          last_o
);

  localparam logic [PW-1:0] PxMax = PW'(CELL_PX - 1);

  logic [PW-1:0] px_q, px_d;
  logic [PW-1:0] py_q, py_d;

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clear_i) begin
      px_d = '0;
      py_d = '0;
    end else if (en_i) begin
      if (px_q == PxMax) begin
        px_d = '0;
        py_d = (py_q == PxMax) ? '0 : py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign px_o   = px_q;
  assign py_o   = py_q;
  assign last_o = (px_q == PxMax) && (py_q == PxMax);

endmodule

// File: rtl/board_renderer.sv
// Renders a BOARD_N x BOARD_N board of CELL_PX-square picture cells to a
// pixel-write port. For each cell: fetch the piece code from board memory,
// then walk the cell's pixels through the picture ROM. ROM data arrives one
// cycle after its address, so the pixel write is pipelined one cycle behind
// the address. An optional select box recolours the border of one cell.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : board_renderer_if master (control, box, memories, pixel port)
module board_renderer
  import render_pkg::*;
#(
  parameter int unsigned BOARD_N  = DefaultBoardN,
  parameter int unsigned CELL_PX  = DefaultCellPx,
  parameter int unsigned ORIGIN_X = DefaultOriginX,
  parameter int unsigned ORIGIN_Y = DefaultOriginY,
  parameter int unsigned PIECE_W  = 4,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned BOX_T    = 2
) (
  input logic               clk,
  input logic               reset,
  board_renderer_if.master  bus
);

  localparam int unsigned CW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam int unsigned PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [CW-1:0] CellMax = CW'(BOARD_N - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cx_q, cx_d;
  logic [CW-1:0]        cy_q, cy_d;
  logic [PIECE_W-1:0]   piece_q, piece_d;

  // Select-box settings, frozen for the whole render at start.
  logic [CW-1:0]        box_x_q, box_y_q;
  logic                 box_en_q;
  logic [COLOUR_W-1:0]  box_colour_q;
  logic                 latch_box;

  // Write pipeline stage: describes the pixel addressed in the previous cycle.
  logic                 wr_q, wr_d;
  logic [8:0]           x_q, x_d;
  logic [7:0]           y_q, y_d;
  logic                 hit_q, hit_d;

  logic                 ctr_clear, ctr_en, ctr_last;
  logic [PW-1:0]        px, py;
  logic                 on_border;

  cell_pixel_counter #(
    .CELL_PX (CELL_PX),
    .PW      (PW)
  ) u_counter (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (ctr_clear),
    .en_i    (ctr_en),
    .px_o    (px),
    .py_o    (py),
    .last_o  (ctr_last)
  );

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    piece_d   = piece_q;
    ctr_clear = 1'b0;
    ctr_en    = 1'b0;
    latch_box = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          latch_box = 1'b1;
          cx_d      = '0;
          cy_d      = '0;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        piece_d   = bus.piece_read;
        ctr_clear = 1'b1;
        state_d   = StDraw;
      end
      StDraw: begin
        ctr_en = 1'b1;
        if (ctr_last) state_d = StFlush;
      end
      StFlush: begin
        if (cx_q == CellMax) begin
          cx_d = '0;
          if (cy_q == CellMax) begin
            cy_d    = '0;
            state_d = StDone;
          end else begin
            cy_d    = cy_q + 1'b1;
            state_d = StFetch;
          end
        end else begin
          cx_d    = cx_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    on_border = (32'(px) < BOX_T) || (32'(px) >= CELL_PX - BOX_T) ||
                (32'(py) < BOX_T) || (32'(py) >= CELL_PX - BOX_T);
    wr_d  = (state_q == StDraw);
    x_d   = 9'(ORIGIN_X) + 9'(cx_q) * 9'(CELL_PX) + 9'(px);
    y_d   = 8'(ORIGIN_Y) + 8'(cy_q) * 8'(CELL_PX) + 8'(py);
    hit_d = box_en_q && (cx_q == box_x_q) && (cy_q == box_y_q) && on_border;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cx_q         <= '0;
      cy_q         <= '0;
      piece_q      <= '0;
      box_x_q      <= '0;
      box_y_q      <= '0;
      box_en_q     <= 1'b0;
      box_colour_q <= '0;
      wr_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      hit_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      piece_q <= piece_d;
      wr_q    <= wr_d;
      if (latch_box) begin
        box_x_q      <= bus.box_x;
        box_y_q      <= bus.box_y;
        box_en_q     <= bus.box_en;
        box_colour_q <= bus.box_colour;
      end
      if (wr_d) begin
        x_q   <= x_d;
        y_q   <= y_d;
        hit_q <= hit_d;
      end
    end
  end

  assign bus.view_x   = cx_q;
  assign bus.view_y   = cy_q;
  assign bus.pic_addr = {piece_q, py, px};
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.writeEn  = wr_q;
  // ROM data lines up with the registered write; hold 0 between writes.
  assign bus.colour   = !wr_q ? '0 : (hit_q ? box_colour_q : bus.pic_pixel);
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);

endmodule

// File: tb/tb_board_renderer.sv
module tb_board_renderer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  board_renderer_if #(
    .BOARD_N  (2),
    .CELL_PX  (4),
    .PIECE_W  (4),
    .COLOUR_W (3)
  ) bus ();

  board_renderer #(
    .BOARD_N  (2),
    .CELL_PX  (4),
    .ORIGIN_X (8),
    .ORIGIN_Y (8),
    .PIECE_W  (4),
    .COLOUR_W (3),
    .BOX_T    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Board memory mem[y][x] and a picture ROM whose colour is piece[2:0]^3'b010.
  logic [3:0] mem [2][2];
  always @(posedge clk) begin
    bus.piece_read <= mem[bus.view_y][bus.view_x];
    bus.pic_pixel  <= bus.pic_addr[6:4] ^ 3'b010;
  end

  int checks = 0;
  int errors = 0;

  // Per-render observations.
  int         wr_cnt [16][16];
  logic [2:0] col_at [16][16];
  logic [3:0] pc_at  [16][16];
  int         wr_total, oob, done_cyc, done_count, wr_after_reset;
  int         p5_total, p5_xmin, p5_xmax;
  logic       view10_seen, busy_after_reset, busy_last;

  task automatic set_board(input logic [3:0] p00, input logic [3:0] p10);
    mem[0][0] = p00;
    mem[0][1] = p10;
    mem[1][0] = 4'd0;
    mem[1][1] = 4'd0;
  endtask

  task automatic run_render(input int restart_cyc, input int reset_cyc, input int stop_cyc);
    logic [3:0] prev_piece;
    int px, py;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        wr_cnt[i][j] = 0;
        col_at[i][j] = '0;
        pc_at[i][j]  = '0;
      end
    wr_total = 0; oob = 0; done_cyc = -1; done_count = 0; wr_after_reset = 0;
    p5_total = 0; p5_xmin = 999; p5_xmax = -1;
    view10_seen = 1'b0; busy_after_reset = 1'b1; busy_last = 1'b1;
    prev_piece = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= stop_cyc; c++) begin
      if (bus.view_x == 1'b1 && bus.view_y == 1'b0) view10_seen = 1'b1;
      if (bus.writeEn) begin
        wr_total++;
        if (c > reset_cyc) wr_after_reset++;
        px = int'(bus.x);
        py = int'(bus.y);
        if (px < 16 && py < 16) begin
          wr_cnt[px][py]++;
          col_at[px][py] = bus.colour;
          pc_at[px][py]  = prev_piece;
        end else begin
          oob++;
        end
        if (prev_piece == 4'd5) begin
          p5_total++;
          if (px < p5_xmin) p5_xmin = px;
          if (px > p5_xmax) p5_xmax = px;
        end
      end
      if (bus.done) begin
        done_count++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == reset_cyc + 1) busy_after_reset = bus.busy;
      busy_last  = bus.busy;
      prev_piece = bus.pic_addr[7:4];
      bus.start  = (c == restart_cyc);
      if (c == restart_cyc) bus.box_x = 1'b0;
      reset = (c != reset_cyc);
      @(negedge clk);
    end
    bus.start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.writeEn !== 1'b0) begin errors++; $display("FAIL reset_writeEn got %b want 0", bus.writeEn); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.x !== 9'd0 || bus.y !== 8'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", bus.x, bus.y); end
    checks++; if (bus.colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d want 0", bus.colour); end
    checks++; if (bus.view_x !== 1'b0 || bus.view_y !== 1'b0) begin errors++; $display("FAIL reset_view got %b,%b want 0,0", bus.view_x, bus.view_y); end
    checks++; if (bus.pic_addr !== 8'd0) begin errors++; $display("FAIL reset_pic_addr got %h want 00", bus.pic_addr); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_render();
    int once, bad_col;
    set_board(4'd0, 4'd0);
    bus.box_en = 1'b0;
    run_render(-1, 1000, 82);
    once = 0; bad_col = 0;
    for (int i = 8; i < 16; i++)
      for (int j = 8; j < 16; j++) begin
        if (wr_cnt[i][j] == 1) once++;
        if (col_at[i][j] != 3'd2) bad_col++;
      end
    checks++; if (wr_total != 64) begin errors++; $display("FAIL full_writes got %0d want 64", wr_total); end
    checks++; if (once != 64 || oob != 0) begin errors++; $display("FAIL full_coverage got once=%0d oob=%0d want 64,0", once, oob); end
    checks++; if (bad_col != 0) begin errors++; $display("FAIL full_colour got %0d wrong want 0", bad_col); end
    checks++; if (done_cyc != 77) begin errors++; $display("FAIL full_done_cycle got %0d want 77", done_cyc); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", done_count); end
    checks++; if (busy_last !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy_last); end
  endtask

  task automatic test_piece();
    int p5_ok, other_ok;
    set_board(4'd0, 4'd5);
    bus.box_en = 1'b0;
    run_render(-1, 1000, 82);
    p5_ok = 0; other_ok = 0;
    for (int i = 8; i < 16; i++)
      for (int j = 8; j < 16; j++) begin
        if (i >= 12 && j < 12) begin
          if (pc_at[i][j] == 4'd5 && col_at[i][j] == 3'd7) p5_ok++;
        end else if (col_at[i][j] == 3'd2) begin
          other_ok++;
        end
      end
    checks++; if (!view10_seen) begin errors++; $display("FAIL piece_view got unseen want (1,0)"); end
    checks++; if (p5_total != 16) begin errors++; $display("FAIL piece_writes got %0d want 16", p5_total); end
    checks++; if (p5_xmin != 12 || p5_xmax != 15) begin errors++; $display("FAIL piece_xrange got %0d..%0d want 12..15", p5_xmin, p5_xmax); end
    checks++; if (p5_ok != 16) begin errors++; $display("FAIL piece_cell got %0d ok want 16", p5_ok); end
    checks++; if (other_ok != 48) begin errors++; $display("FAIL piece_others got %0d ok want 48", other_ok); end
    checks++; if (done_cyc != 77) begin errors++; $display("FAIL piece_done_cycle got %0d want 77", done_cyc); end
  endtask

  // Counts box-coloured border / ROM-coloured interior pixels of cell (1,1)
  // and box-coloured pixels anywhere else.
  task automatic count_box(output int border_ok, output int inner_ok, output int stray);
    border_ok = 0; inner_ok = 0; stray = 0;
    for (int i = 8; i < 16; i++)
      for (int j = 8; j < 16; j++) begin
        if (i >= 12 && j >= 12) begin
          if (i == 12 || i == 15 || j == 12 || j == 15) begin
            if (col_at[i][j] == 3'd4) border_ok++;
          end else if (col_at[i][j] == 3'd2) begin
            inner_ok++;
          end
        end else if (col_at[i][j] == 3'd4) begin
          stray++;
        end
      end
  endtask

  task automatic test_box();
    int border_ok, inner_ok, stray;
    set_board(4'd0, 4'd0);
    bus.box_en = 1'b1; bus.box_x = 1'b1; bus.box_y = 1'b1; bus.box_colour = 3'b100;
    run_render(-1, 1000, 82);
    count_box(border_ok, inner_ok, stray);
    checks++; if (border_ok != 12) begin errors++; $display("FAIL box_border got %0d want 12", border_ok); end
    checks++; if (inner_ok != 4) begin errors++; $display("FAIL box_interior got %0d want 4", inner_ok); end
    checks++; if (stray != 0) begin errors++; $display("FAIL box_stray got %0d want 0", stray); end
  endtask

  task automatic test_restart_ignored();
    int border_ok, inner_ok, stray;
    set_board(4'd0, 4'd0);
    bus.box_en = 1'b1; bus.box_x = 1'b1; bus.box_y = 1'b1; bus.box_colour = 3'b100;
    run_render(10, 1000, 82);
    count_box(border_ok, inner_ok, stray);
    checks++; if (done_cyc != 77) begin errors++; $display("FAIL restart_done_cycle got %0d want 77", done_cyc); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", done_count); end
    checks++; if (wr_total != 64) begin errors++; $display("FAIL restart_writes got %0d want 64", wr_total); end
    checks++; if (border_ok != 12 || stray != 0) begin errors++; $display("FAIL restart_box got border=%0d stray=%0d want 12,0", border_ok, stray); end
  endtask

  task automatic test_reset_abort();
    bus.box_en = 1'b0;
    set_board(4'd0, 4'd0);
    run_render(-1, 30, 90);
    checks++; if (wr_after_reset != 0) begin errors++; $display("FAIL abort_writes got %0d want 0", wr_after_reset); end
    checks++; if (done_count != 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_count); end
    checks++; if (busy_after_reset !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_after_reset); end
    run_render(-1, 1000, 82);
    checks++; if (wr_total != 64) begin errors++; $display("FAIL abort_rerun_writes got %0d want 64", wr_total); end
    checks++; if (done_cyc != 77) begin errors++; $display("FAIL abort_rerun_done got %0d want 77", done_cyc); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.box_x = 1'b0;
    bus.box_y = 1'b0;
    bus.box_en = 1'b0;
    bus.box_colour = 3'd0;
    set_board(4'd0, 4'd0);
    @(negedge clk);
    test_reset();
    test_full_render();
    test_piece();
    test_box();
    test_restart_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameter BOARD_N, default 8: cells per board side.
REQ-002 Parameter CELL_PX, default 28: pixels per cell side.
REQ-003 Parameter ORIGIN_X, default 8: screen x of the board's top-left pixel.
REQ-004 Parameter ORIGIN_Y, default 8: screen y of the board's top-left pixel.
REQ-005 Parameter PIECE_W, default 4: piece code width.
REQ-006 Parameter COLOUR_W, default 3: pixel colour width.
REQ-007 Parameter BOX_T, default 2: select-box border thickness in pixels.
REQ-008 Derived widths: CW = clog2(BOARD_N); PW = clog2(CELL_PX).
REQ-009 clk  input  1  sole clock, rising edge.
REQ-010 reset  input  1  synchronous, active-low reset.
REQ-011 start  input  1  one-cycle request to render the full board.
REQ-012 box_x, box_y  input  CW each  select-box cell.
REQ-013 box_en  input  1  draw the select box.
REQ-014 box_colour  input  COLOUR_W  select-box colour (e.g. per current player).
REQ-015 piece_read  input  PIECE_W  board memory data, valid 1 cycle after view_x/view_y.
REQ-016 pic_pixel  input  COLOUR_W  picture ROM data, valid 1 cycle after pic_addr.
REQ-017 view_x, view_y  output  CW each  board memory address.
REQ-018 pic_addr  output  PIECE_W+2*PW  {piece, py, px} picture ROM address.
REQ-019 x  output  9  screen x; y  output  8  screen y.
REQ-020 colour  output  COLOUR_W  pixel colour.
REQ-021 writeEn  output  1  pixel write strobe to the VGA adapter.
REQ-022 busy  output  1  high while rendering.
REQ-023 done  output  1  one-cycle pulse when the render completes.

Function
REQ-024 FSM states: IDLE, FETCH, LATCH, DRAW, FLUSH, DONE.
REQ-025 IDLE: busy=0; on start=1, latch box_x/box_y/box_en/box_colour, clear cell counters, go to FETCH.
REQ-026 FETCH: drive view_x=cx, view_y=cy for one cycle, then go to LATCH.
REQ-027 LATCH: capture piece_read into a piece register, clear px/py, go to DRAW.
REQ-028 DRAW: issue pic_addr={piece,py,px} each cycle, px fastest, raster order; after px=py=CELL_PX-1, go to FLUSH.
REQ-029 Write pipeline: the pixel addressed in cycle t is written in cycle t+1 with writeEn=1, x=ORIGIN_X+cx*CELL_PX+px, y=ORIGIN_Y+cy*CELL_PX+py, colour=pic_pixel.
REQ-030 FLUSH: complete the last pipelined write; advance cx, wrapping to 0 and incrementing cy; go to FETCH, or to DONE after cell (BOARD_N-1,BOARD_N-1).
REQ-031 DONE: done=1 for exactly one cycle, then IDLE.
REQ-032 Select-box override: if the latched box_en=1, the cell equals the latched box, and px<BOX_T, px>=CELL_PX-BOX_T, py<BOX_T or py>=CELL_PX-BOX_T, then colour=latched box_colour.
REQ-033 Latency per cell is 2+CELL_PX^2+1 cycles; a full render takes BOARD_N^2*(CELL_PX^2+3)+1 cycles from start to the done pulse.
REQ-034 Each screen pixel of the board is written exactly once per render; writeEn=0 outside DRAW/FLUSH write slots.
REQ-035 start while busy=1 is ignored; box input changes mid-render have no effect until the next start.
REQ-036 start and done may coincide only in IDLE after DONE; start in the DONE cycle is ignored.
REQ-037 Screen coordinate arithmetic uses 9-bit (x) and 8-bit (y) unsigned values; parameters are chosen so no overflow occurs; no wrap logic is required.

Reset
REQ-038 reset=0 at a clock edge forces IDLE and sets x, y, colour, view_x, view_y, pic_addr and all counters to 0, with writeEn=busy=done=0.
REQ-039 Reset mid-render aborts the render immediately with no further writeEn pulses and no done pulse.

Structure
REQ-040 The state encoding and the default geometry constants (BOARD_N, CELL_PX, ORIGIN_X, ORIGIN_Y) live in shared package render_pkg.
REQ-041 One sub-module, cell_pixel_counter, generates px/py and the last-pixel flag; everything else is in board_renderer.

Verification (bench parameters BOARD_N=2, CELL_PX=4, ORIGIN=(8,8), BOX_T=1)
REQ-042 Reset, then one start with all pieces 0 and pic_pixel=3'b010: exactly 64 writes at x 8..15, y 8..15, all colour 2, and done after 77 cycles.
REQ-043 Piece at (1,0)=5: view address (1,0) is observed, pic_addr piece field=5 for that cell's 16 writes, and their x range is 12..15.
REQ-044 box_en=1, box=(1,1), box_colour=3'b100: the 12 border pixels of cell (1,1) have colour 4 and its 4 interior pixels have the ROM colour.
REQ-045 start again at cycle 10 of a render, and change box_x at the same time: no restart, and done still lands at cycle 77 with the original box.
REQ-046 reset=0 at cycle 30: writeEn=0 from the next cycle, no done pulse, busy=0, and a subsequent start renders normally.
